// File: rtl/sha256_req_arbiter.sv
// Round-robin arbiter that shares one sha256_core between N_REQ block requesters,
// sequences the core start/ready handshake and recovers the core on a watchdog timeout.
module sha256_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*512-1:0]   req_block_i,
  output logic [N_REQ-1:0]       req_ack_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [255:0]           rsp_hash_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [7:0]             err_cnt_o,
  output logic                   core_rst_o,
  output logic                   core_start_o,
  output logic [511:0]           core_block_o,
  input  logic [255:0]           core_hash_i,
  input  logic                   core_ready_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_RESP  = 3'd3,
    S_RECOV = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [15:0]        wdog_q, wdog_d;
  logic [1:0]         rcnt_q, rcnt_d;
  logic               core_rst_q, core_rst_d;
  logic               core_start_q, core_start_d;
  logic [511:0]       core_block_q, core_block_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [255:0]       rsp_hash_q, rsp_hash_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               busy_q, busy_d;

  logic               pick_found_s;
  logic [IW-1:0]      pick_idx_s;
  logic [IW-1:0]      cand_s;
  logic               wdog_hit_s;

  // Round-robin search: walk from rr_ptr+N down to rr_ptr+1 so the nearest requester wins last.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = rr_ptr_q;
    cand_s       = rr_ptr_q;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s = IW'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid_i[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  assign wdog_hit_s = (wdog_q == WDOG_LAST);

  // Next-state and output logic of the job sequencer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    wdog_d       = wdog_q;
    rcnt_d       = rcnt_q;
    core_rst_d   = core_rst_q;
    core_start_d = core_start_q;
    core_block_d = core_block_q;
    req_ack_d    = '0;
    rsp_valid_d  = '0;
    rsp_hash_d   = rsp_hash_q;
    rsp_err_d    = rsp_err_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (core_rst_q) begin
          core_rst_d = 1'b0;
        end else if (pick_found_s) begin
          core_block_d          = req_block_i[512*pick_idx_s +: 512];
          req_ack_d[pick_idx_s] = 1'b1;
          gnt_d                 = pick_idx_s;
          rr_ptr_d              = pick_idx_s;
          core_start_d          = 1'b1;
          wdog_d                = 16'd0;
          state_d               = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      // The core drops its sticky ready once it has taken the job; only then is a rising ready a result.
      S_START: begin
        if (wdog_hit_s) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_hash_d         = 256'd0;
          err_cnt_d          = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          core_start_d       = 1'b0;
          core_rst_d         = 1'b1;
          rcnt_d             = 2'd0;
          state_d            = S_RECOV;
        end else if (!core_ready_i) begin
          wdog_d  = wdog_q + 16'd1;
          state_d = S_BUSY;
        end else begin
          wdog_d  = wdog_q + 16'd1;
        end
      end

      S_BUSY: begin
        if (core_ready_i) begin
          rsp_hash_d         = core_hash_i;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b0;
          core_start_d       = 1'b0;
          state_d            = S_RESP;
        end else if (wdog_hit_s) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_hash_d         = 256'd0;
          err_cnt_d          = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          core_start_d       = 1'b0;
          core_rst_d         = 1'b1;
          rcnt_d             = 2'd0;
          state_d            = S_RECOV;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      S_RECOV: begin
        if (rcnt_q == 2'd1) begin
          core_rst_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          rcnt_d = rcnt_q + 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; core_rst comes up asserted so the core starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IW'(N_REQ - 1);
      gnt_q        <= '0;
      wdog_q       <= 16'd0;
      rcnt_q       <= 2'd0;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
      core_block_q <= 512'd0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_hash_q   <= 256'd0;
      rsp_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      wdog_q       <= wdog_d;
      rcnt_q       <= rcnt_d;
      core_rst_q   <= core_rst_d;
      core_start_q <= core_start_d;
      core_block_q <= core_block_d;
      req_ack_q    <= req_ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hash_q   <= rsp_hash_d;
      rsp_err_q    <= rsp_err_d;
      err_cnt_q    <= err_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ack_o    = req_ack_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hash_o   = rsp_hash_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign err_cnt_o    = err_cnt_q;
  assign core_rst_o   = core_rst_q;
  assign core_start_o = core_start_q;
  assign core_block_o = core_block_q;

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Scoreboard bench for sha256_req_arbiter with a behavioural sha256_core stand-in
// that answers known single-block messages with their published digests.
module tb_sha256_req_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 8;

  localparam logic [511:0] B_ABC   = {32'h61626380, 32'h00000000, 416'd0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 32'h00000000, 416'd0, 32'h00000000};
  localparam logic [511:0] B_A     = {32'h61800000, 32'h00000000, 416'd0, 32'h00000008};
  localparam logic [511:0] B_HELLO = {32'h68656c6c, 32'h6f800000, 416'd0, 32'h00000028};
  localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] H_A     = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] H_HELLO = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ*512-1:0] req_block = {B_HELLO, B_A, B_EMPTY, B_ABC};
  logic [N_REQ-1:0]     req_ack_o, rsp_valid_o;
  logic [255:0]         rsp_hash_o;
  logic                 rsp_err_o, busy_o, core_rst_o, core_start_o;
  logic [7:0]           err_cnt_o;
  logic [511:0]         core_block_o;
  logic [255:0]         core_hash = 256'd0;
  logic                 core_ready = 1'b1;
  logic                 core_stuck = 1'b0;

  sha256_req_arbiter #(.N_REQ(N_REQ), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_block_i(req_block),
    .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o),
    .rsp_hash_o(rsp_hash_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o),
    .core_rst_o(core_rst_o), .core_start_o(core_start_o),
    .core_block_o(core_block_o), .core_hash_i(core_hash),
    .core_ready_i(core_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int            idx;
    logic          err;
    logic [255:0]  hash;
  } rsp_t;

  int   ack_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] digest_of(input logic [511:0] blk);
    if (blk == B_ABC)        return H_ABC;
    else if (blk == B_EMPTY) return H_EMPTY;
    else if (blk == B_A)     return H_A;
    else if (blk == B_HELLO) return H_HELLO;
    else                     return 256'hbad;
  endfunction

  // Core stand-in: IDLE (ready=1) -> RUN (ready=0, LAT cycles) -> DONE (ready=1) until start drops.
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} cst_e;
  cst_e         cst = C_IDLE;
  int           ccnt = 0;
  logic [511:0] cblk = 512'd0;
  always @(posedge clk) begin
    if (core_rst_o) begin
      cst <= C_IDLE; core_ready <= 1'b1; core_hash <= 256'd0; ccnt <= 0;
    end else begin
      case (cst)
        C_IDLE: if (core_start_o) begin
          cblk <= core_block_o; cst <= C_RUN; core_ready <= 1'b0; ccnt <= 0;
        end
        C_RUN: if (!core_stuck) begin
          if (ccnt == LAT - 1) begin
            core_ready <= 1'b1; core_hash <= digest_of(cblk); cst <= C_DONE;
          end else begin
            ccnt <= ccnt + 1;
          end
        end
        C_DONE: if (!core_start_o) cst <= C_IDLE;
        default: cst <= C_IDLE;
      endcase
    end
  end

  // Monitor: every ack / response pulse is matched against the next scoreboard entry.
  logic [N_REQ-1:0] m_exp;
  rsp_t             m_r;
  int               m_i;
  always @(negedge clk) begin
    if (req_ack_o != '0) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 256'(req_ack_o), 256'd0);
      else begin
        m_i = ack_q.pop_front();
        m_exp = 4'b0001 << m_i;
        chk("ack_idx", 256'(req_ack_o), 256'(m_exp));
      end
    end
    if (rsp_valid_o != '0) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 256'(rsp_valid_o), 256'd0);
      else begin
        m_r = rsp_q.pop_front();
        m_exp = 4'b0001 << m_r.idx;
        chk("rsp_idx", 256'(rsp_valid_o), 256'(m_exp));
        chk("rsp_err", 256'(rsp_err_o), 256'(m_r.err));
        chk("rsp_hash", rsp_hash_o, m_r.hash);
      end
    end
  end

  task automatic push_job(input int idx, input logic err, input logic [255:0] h);
    rsp_t r;
    r.idx = idx; r.err = err; r.hash = h;
    ack_q.push_back(idx);
    rsp_q.push_back(r);
  endtask

  // Runs until the scoreboard drains; requesters drop valid on ack (plus any extra_drop bits).
  task automatic drain(input int budget, input logic [N_REQ-1:0] extra_drop, input logic chk_gap);
    int   acks = 0;
    logic gap  = 1'b0;
    int   n    = 0;
    while ((ack_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (req_ack_o != '0) begin
        if (chk_gap && acks > 0) chk("start_gap", 256'(gap), 256'd1);
        acks++;
        gap = 1'b0;
        req_valid = req_valid & ~(req_ack_o | extra_drop);
      end else if (!core_start_o) begin
        gap = 1'b1;
      end
    end
    #1;
    chk("drain_timeout", 256'(ack_q.size() + rsp_q.size()), 256'd0);
  endtask

  task automatic do_reset(input logic [N_REQ-1:0] valid_during);
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_valid = valid_during;
    #1;
    chk("rst_core_rst", 256'(core_rst_o), 256'd1);
    chk("rst_core_start", 256'(core_start_o), 256'd0);
    chk("rst_busy", 256'(busy_o), 256'd0);
    chk("rst_rsp_valid", 256'(rsp_valid_o), 256'd0);
    chk("rst_err_cnt", 256'(err_cnt_o), 256'd0);
    chk("rst_rsp_hash", rsp_hash_o, 256'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic submit_one(input int idx);
    @(posedge clk);
    #1 req_valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ack_one_cycle", 256'(req_ack_o), 256'(4'b0001 << idx));
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  int lat;
  int cnt3;

  initial begin
    // Test 1: single "abc" request.
    do_reset('0);
    repeat (3) @(posedge clk);
    push_job(0, 1'b0, H_ABC);
    submit_one(0);
    chk("t1_busy", 256'(busy_o), 256'd1);
    chk("t1_core_block", 256'(core_block_o[511:480]), 256'h61626380);
    drain(60, '0, 1'b0);

    // Test 2: all four valid from reset, grant order 0..3.
    do_reset(4'b1111);
    push_job(0, 1'b0, H_ABC);
    push_job(1, 1'b0, H_EMPTY);
    push_job(2, 1'b0, H_A);
    push_job(3, 1'b0, H_HELLO);
    drain(200, '0, 1'b1);

    // Test 3: rr_ptr=3, only req 2 -> immediate grant, correct digest despite sticky ready.
    push_job(2, 1'b0, H_A);
    submit_one(2);
    drain(60, '0, 1'b0);

    // Test 4: stuck core, timeout at cycle 20 after start.
    core_stuck = 1'b1;
    push_job(0, 1'b1, 256'd0);
    submit_one(0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid_o != '0) begin
        lat = n;
        break;
      end
    end
    chk("t4_timeout_latency", 256'(lat), 256'd20);
    chk("t4_err_cnt", 256'(err_cnt_o), 256'd1);
    chk("t4_core_rst_c0", 256'(core_rst_o), 256'd1);
    @(negedge clk);
    chk("t4_core_rst_c1", 256'(core_rst_o), 256'd1);
    @(negedge clk);
    chk("t4_core_rst_c2", 256'(core_rst_o), 256'd0);
    core_stuck = 1'b0;
    push_job(0, 1'b0, H_ABC);
    submit_one(0);
    drain(60, '0, 1'b0);

    // Test 5: async reset mid-BUSY on req 1, then resubmit.
    ack_q.push_back(1);
    submit_one(1);
    repeat (6) @(negedge clk);
    chk("t5_busy_before_rst", 256'(busy_o), 256'd1);
    do_reset('0);
    repeat (30) @(negedge clk);
    push_job(1, 1'b0, H_EMPTY);
    submit_one(1);
    drain(60, '0, 1'b0);

    // Test 6: req 3 withdrawn before grant while req 1 is serviced.
    do_reset(4'b1010);
    push_job(1, 1'b0, H_EMPTY);
    drain(60, 4'b1000, 1'b0);
    cnt3 = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ack_o[3] || rsp_valid_o[3]) cnt3++;
    end
    chk("t6_req3_activity", 256'(cnt3), 256'd0);

    chk("final_ack_q", 256'(ack_q.size()), 256'd0);
    chk("final_rsp_q", 256'(rsp_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
